// File: rtl/fpu_op_sequencer.sv
`timescale 1ns/1ps
// Purpose : operand/result sequencer around a multi-cycle FPU core.
// Latency : result offered exactly FPU_LATENCY cycles after the operand accept.
// Backpr. : one operation in flight; in_ready low until the result is handshaken.
//
// Ports:
//   clock_100k, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_a/b   operand pair handshake
//   op_a, op_b                 operands held stable toward the FPU core
//   fpu_data, fpu_status       FPU outputs, sampled once when the latency expires
//   res_valid/res_ready/       captured result handshake
//   res_data/res_status
//   busy                       high whenever an operation is outstanding
//   op_count                   completed result handshakes, wraps silently
module fpu_op_sequencer #(
   parameter int WIDTH       = 32,
   parameter int STATUS_W    = 4,
   parameter int FPU_LATENCY = 24,
   parameter int CNT_W       = 16
) (
   input  logic                clock_100k,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   output logic [WIDTH-1:0]    op_a,
   output logic [WIDTH-1:0]    op_b,
   input  logic [WIDTH-1:0]    fpu_data,
   input  logic [STATUS_W-1:0] fpu_status,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [WIDTH-1:0]    res_data,
   output logic [STATUS_W-1:0] res_status,
   output logic                busy,
   output logic [CNT_W-1:0]    op_count
);

   // Counter only needs to hold FPU_LATENCY-1; keep at least one bit.
   localparam int LAT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state;
   logic [LAT_W-1:0] cnt;

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clock_100k) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_status <= '0;
         op_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_a  <= in_a;
                  op_b  <= in_b;
                  cnt   <= LAT_W'(FPU_LATENCY - 1);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // cnt reaching zero marks the FPU_LATENCY-th edge after accept,
               // the only edge on which the FPU outputs are sampled.
               if (cnt == '0) begin
                  res_data   <= fpu_data;
                  res_status <= fpu_status;
                  res_valid  <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  cnt <= cnt - LAT_W'(1);
               end
            end
            S_DONE: begin
               // res_data/res_status deliberately left untouched after handshake.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for fpu_op_sequencer (default latency and latency 1).
// Latency : expected result time recorded at accept, compared when res_valid rises.
// Backpr. : res_ready driven per scenario; in_valid only asserted when idle is wanted.
module tb_fpu_op_sequencer;

   localparam int LAT_A = 24;
   localparam int LAT_B = 1;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  status;
      int          when;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   logic scramble = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // DUT A: default parameters
   logic        in_valid_a, in_ready_a, res_valid_a, res_ready_a, busy_a;
   logic [31:0] in_a_a, in_b_a, op_a_a, op_b_a, fpu_data_a, res_data_a;
   logic [3:0]  fpu_status_a, res_status_a;
   logic [15:0] op_count_a;

   // DUT B: latency 1, 4-bit op counter
   logic        in_valid_b, in_ready_b, res_valid_b, res_ready_b, busy_b;
   logic [31:0] in_a_b, in_b_b, op_a_b, op_b_b, fpu_data_b, res_data_b;
   logic [3:0]  fpu_status_b, res_status_b;
   logic [3:0]  op_count_b;

   fpu_op_sequencer #(.WIDTH(32), .STATUS_W(4), .FPU_LATENCY(LAT_A), .CNT_W(16)) dut_a (
      .clock_100k(clk), .reset(reset),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_a(in_a_a), .in_b(in_b_a),
      .op_a(op_a_a), .op_b(op_b_a), .fpu_data(fpu_data_a), .fpu_status(fpu_status_a),
      .res_valid(res_valid_a), .res_ready(res_ready_a), .res_data(res_data_a),
      .res_status(res_status_a), .busy(busy_a), .op_count(op_count_a)
   );

   fpu_op_sequencer #(.WIDTH(32), .STATUS_W(4), .FPU_LATENCY(LAT_B), .CNT_W(4)) dut_b (
      .clock_100k(clk), .reset(reset),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_a(in_a_b), .in_b(in_b_b),
      .op_a(op_a_b), .op_b(op_b_b), .fpu_data(fpu_data_b), .fpu_status(fpu_status_b),
      .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b),
      .res_status(res_status_b), .busy(busy_b), .op_count(op_count_b)
   );

   // Hand-computed FPU results for the operand pairs used here: {status, data}.
   function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3FF00000, 32'h3FF00000}: return {4'h0, 32'h40000000}; // 1+1=2
         {32'h3FF00000, 32'h40000000}: return {4'h0, 32'h40080000}; // 1+2=3
         {32'h40000000, 32'hBFF00000}: return {4'h0, 32'h3FF00000}; // 2-1=1
         {32'hC0080000, 32'hC0000000}: return {4'h0, 32'hC0140000}; // -3-2=-5
         {32'h7FEFFFFF, 32'h7FEFFFFF}: return {4'h1, 32'h7FF00000}; // overflow
         default:                      return {4'h0, 32'h00000000};
      endcase
   endfunction

   // The FPU holds its output while operands are stable; scramble models the
   // core moving on after the sequencer has already captured.
   always_comb begin
      {fpu_status_a, fpu_data_a} = fpu_model(op_a_a, op_b_a);
      if (scramble) begin
         fpu_data_a   = ~fpu_data_a;
         fpu_status_a = 4'h0;
      end
   end

   always_comb begin
      {fpu_status_b, fpu_data_b} = fpu_model(op_a_b, op_b_b);
   end

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [15:0] exp_cnt_a = '0;
   logic [3:0]  exp_cnt_b = '0;
   logic        prev_a = 1'b0;
   logic        prev_b = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor A: samples after each active edge. prev_a is res_valid before the
   // edge and res_ready has been stable since the preceding negedge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (reset) begin
         q_a.delete();
         exp_cnt_a = '0;
         prev_a    = 1'b0;
      end else begin
         if (prev_a && res_ready_a) begin
            exp_cnt_a++;
            chk("a_op_count", 32'(op_count_a), 32'(exp_cnt_a));
            chk("a_vld_drop", 32'(res_valid_a), 32'd0);
         end
         if (res_valid_a && !prev_a) begin
            if (q_a.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL a_unexpected_result actual=%h expected=none", res_data_a);
            end else begin
               e = q_a.pop_front();
               chk("a_res_data", res_data_a, e.data);
               chk("a_res_status", 32'(res_status_a), 32'(e.status));
               chk("a_res_latency", 32'(cyc), 32'(e.when));
            end
         end
         prev_a = res_valid_a;
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (reset) begin
         q_b.delete();
         exp_cnt_b = '0;
         prev_b    = 1'b0;
      end else begin
         if (prev_b && res_ready_b) begin
            exp_cnt_b++;
            chk("b_op_count", 32'(op_count_b), 32'(exp_cnt_b));
         end
         if (res_valid_b && !prev_b) begin
            if (q_b.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected_result actual=%h expected=none", res_data_b);
            end else begin
               e = q_b.pop_front();
               chk("b_res_data", res_data_b, e.data);
               chk("b_res_status", 32'(res_status_b), 32'(e.status));
               chk("b_res_latency", 32'(cyc), 32'(e.when));
            end
         end
         prev_b = res_valid_b;
      end
   end

   task automatic issue_a(input logic [31:0] a, input logic [31:0] b);
      logic [35:0] m;
      exp_t        e;
      int          g;
      m = fpu_model(a, b);
      @(negedge clk);
      in_valid_a = 1'b1;
      in_a_a     = a;
      in_b_a     = b;
      g = 0;
      while (!in_ready_a && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready_a) begin
         checks++;
         failures++;
         $display("FAIL a_accept_timeout actual=busy expected=ready");
         in_valid_a = 1'b0;
         return;
      end
      e.data   = m[31:0];
      e.status = m[35:32];
      e.when   = cyc + 1 + LAT_A;
      q_a.push_back(e);
      @(negedge clk);
      in_valid_a = 1'b0;
      chk("a_op_a", op_a_a, a);
      chk("a_op_b", op_b_a, b);
      chk("a_busy", 32'(busy_a), 32'd1);
   endtask

   task automatic wait_vld_a();
      int g = 0;
      while (!res_valid_a && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("a_vld_timeout", 32'(res_valid_a), 32'd1);
   endtask

   task automatic wait_idle_a();
      int g = 0;
      while (!in_ready_a && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("a_idle_timeout", 32'(in_ready_a), 32'd1);
   endtask

   initial begin
      int   n;
      int   g;
      exp_t e;
      reset       = 1'b1;
      in_valid_a  = 1'b0; in_a_a = '0; in_b_a = '0; res_ready_a = 1'b0;
      in_valid_b  = 1'b0; in_a_b = '0; in_b_b = '0; res_ready_b = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_in_ready", 32'(in_ready_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_res_valid", 32'(res_valid_a), 32'd0);
      chk("rst_op_a", op_a_a, 32'h0);
      chk("rst_res_data", res_data_a, 32'h0);
      chk("rst_op_count", 32'(op_count_a), 32'd0);

      // 1: 1.0 + 1.0
      res_ready_a = 1'b1;
      issue_a(32'h3FF00000, 32'h3FF00000);
      wait_idle_a();
      chk("t1_op_count", 32'(op_count_a), 32'd1);

      // 2: result held under backpressure, stray in_valid ignored
      res_ready_a = 1'b0;
      issue_a(32'h3FF00000, 32'h40000000);
      wait_vld_a();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_hold_data", res_data_a, 32'h40080000);
         chk("t2_hold_status", 32'(res_status_a), 32'd0);
         chk("t2_in_ready", 32'(in_ready_a), 32'd0);
         chk("t2_op_count", 32'(op_count_a), 32'd1);
         if (i == 4) begin
            in_valid_a = 1'b1;
            in_a_a     = 32'h40140000;
            in_b_a     = 32'h00000000;
         end else begin
            in_valid_a = 1'b0;
         end
      end
      @(negedge clk);
      chk("t2_op_a_kept", op_a_a, 32'h3FF00000);
      chk("t2_op_b_kept", op_b_a, 32'h40000000);
      res_ready_a = 1'b1;
      wait_idle_a();
      chk("t2_op_count_after", 32'(op_count_a), 32'd2);
      chk("t2_data_kept", res_data_a, 32'h40080000);

      // 3: two ops streamed, results in order
      issue_a(32'h40000000, 32'hBFF00000);
      wait_idle_a();
      issue_a(32'hC0080000, 32'hC0000000);
      wait_idle_a();
      chk("t3_op_count", 32'(op_count_a), 32'd4);

      // 4: reset mid-WAIT abandons the operation
      issue_a(32'h3FF00000, 32'h3FF00000);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t4_op_a", op_a_a, 32'h0);
      chk("t4_op_b", op_b_a, 32'h0);
      chk("t4_op_count", 32'(op_count_a), 32'd0);
      chk("t4_in_ready", 32'(in_ready_a), 32'd1);
      chk("t4_res_data", res_data_a, 32'h0);
      repeat (40) @(negedge clk);
      chk("t4_no_result", 32'(res_valid_a), 32'd0);
      issue_a(32'h3FF00000, 32'h3FF00000);
      wait_idle_a();
      chk("t4_recover_count", 32'(op_count_a), 32'd1);

      // 5: overflow status captured once, FPU changes afterwards
      res_ready_a = 1'b0;
      issue_a(32'h7FEFFFFF, 32'h7FEFFFFF);
      wait_vld_a();
      @(negedge clk);
      scramble = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_data", res_data_a, 32'h7FF00000);
         chk("t5_status", 32'(res_status_a), 32'd1);
      end
      res_ready_a = 1'b1;
      wait_idle_a();
      scramble = 1'b0;
      chk("t5_op_count", 32'(op_count_a), 32'd2);

      // 6: latency 1, 17 back-to-back ops, 4-bit counter wraps
      in_a_b = 32'h3FF00000;
      in_b_b = 32'h3FF00000;
      @(negedge clk);
      in_valid_b = 1'b1;
      n = 0;
      g = 0;
      while (n < 17 && g < 200) begin
         if (in_ready_b) begin
            e.data   = 32'h40000000;
            e.status = 4'h0;
            e.when   = cyc + 1 + LAT_B;
            q_b.push_back(e);
            n++;
         end
         @(negedge clk);
         g++;
      end
      in_valid_b = 1'b0;
      chk("t6_accepts", 32'(n), 32'd17);
      repeat (4) @(negedge clk);
      chk("t6_op_count_wrap", 32'(op_count_b), 32'd1);
      chk("t6_idle", 32'(in_ready_b), 32'd1);

      repeat (3) @(negedge clk);
      chk("end_q_a_empty", 32'(q_a.size()), 32'd0);
      chk("end_q_b_empty", 32'(q_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
